wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width.
REQ-003 SHALL have parameter TMO, default 8, timeout counter width in bits; timeout limit = 2^TMO-1 cycles.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 arstn  input  1  reset, asynchronous, active-low.
REQ-006 mN_adr_i (N=0,1)  input  AW  master N address.
REQ-007 mN_dat_i  input  DW  master N write data.
REQ-008 mN_we_i  input  1  master N write enable.
REQ-009 mN_stb_i  input  1  master N strobe; level request, held until ack or err.
REQ-010 mN_dat_o  output  DW  read data to master N.
REQ-011 mN_ack_o  output  1  transfer complete to master N.
REQ-012 mN_err_o  output  1  timeout error to master N, one-cycle pulse.
REQ-013 s_adr_o  output  AW  slave address.
REQ-014 s_dat_o  output  DW  slave write data.
REQ-015 s_we_o  output  1  slave write enable.
REQ-016 s_stb_o  output  1  slave strobe.
REQ-017 s_dat_i  input  DW  slave read data.
REQ-018 s_ack_i  input  1  slave acknowledge.
REQ-019 owner  output  1  current grant holder; valid while busy is high.
REQ-020 busy  output  1  high while a grant is held.

Function
REQ-021 SHALL implement states IDLE and BUSY plus registers owner, last (last master served), tcount (TMO bits).
REQ-022 IDLE: no stb -> stay IDLE; one mN_stb_i high -> BUSY, owner=N; both high -> BUSY, owner = ~last (round-robin).
REQ-023 Grant latency SHALL be exactly one cycle: stb first sampled high in IDLE, s_stb_o high the following cycle.
REQ-024 In BUSY, s_stb_o, s_adr_o, s_dat_o, s_we_o SHALL combinationally follow the owner's stb/adr/dat/we; in IDLE s_stb_o=0, s_we_o=0.
REQ-025 mN_ack_o = s_ack_i & BUSY & owner==N; ack to non-owner or in IDLE SHALL be ignored.
REQ-026 mN_dat_o SHALL equal s_dat_i for both masters (qualified only by ack).
REQ-027 BUSY with s_ack_i & s_stb_o -> IDLE next edge, last<=owner, tcount<=0; back-to-back request re-arbitrated from IDLE (one idle cycle min between transfers).
REQ-028 BUSY with owner stb dropped before ack (abort) -> IDLE, last<=owner, no ack or err issued.
REQ-029 tcount SHALL increment each BUSY cycle without ack; when tcount==2^TMO-1 and no ack that cycle, owner's mN_err_o pulses that cycle, next state IDLE, last<=owner, tcount<=0.
REQ-030 Ack on the same cycle as timeout terminal count SHALL take priority: ack issued, no err.
REQ-031 A non-owner request arriving during BUSY SHALL wait; it is never dropped while stb held, and wins next arbitration by round-robin.

Reset
REQ-032 On arstn low, asynchronously: state=IDLE, owner=0, last=1, tcount=0; thus busy=0, s_stb_o=0, s_we_o=0, all mN_ack_o=0, mN_err_o=0.
REQ-033 Reset mid-transfer SHALL abort without ack or err; first post-reset simultaneous request goes to master 0.

Verification
REQ-034 m0 write adr=0x0010 dat=0xDEADBEEF, slave acks 1 cycle after s_stb_o -> s_stb_o high cycle 1 after request, s_we_o=1, m0_ack_o one cycle, busy falls, m1 outputs stay 0.
REQ-035 m0 and m1 both request after reset, four transfers each -> grants alternate 0,1,0,1,...; owner matches each ack.
REQ-036 m1 read, slave returns s_dat_i=0x12345678 with ack -> m1_ack_o=1 and m1_dat_o=0x12345678 same cycle; m0_ack_o=0.
REQ-037 TMO=4, slave never acks, m0 requests -> m0_err_o pulses exactly once 15 cycles into BUSY, state IDLE next; ack at cycle 15 instead -> ack, no err.
REQ-038 m1 drops stb after 2 BUSY cycles while m0 pending -> no m1 ack/err, m0 granted after one IDLE cycle.
REQ-039 Assert arstn low during BUSY with pending ack -> all outputs zero immediately; after release, dual request grants m0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles both master ports, the shared slave port and the grant status of the 2:1 Wishbone arbiter.
// The slave modport is the arbiter's own view; the master modport is the view of whatever drives the masters and the slave.
interface wb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_we_i, m1_we_i;
    logic          m0_stb_i, m1_stb_i;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o;
    logic          m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o, s_stb_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic          owner, busy;

    modport slave (
        input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i, m0_stb_i, m1_stb_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output s_adr_o, s_dat_o, s_we_o, s_stb_o, owner, busy
    );

    modport master (
        output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i, m0_stb_i, m1_stb_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_we_o, s_stb_o, owner, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin Wishbone arbiter with one-cycle grant latency and a transfer timeout.
module wb_arbiter #(
    parameter int AW  = 15,
    parameter int DW  = 32,
    parameter int TMO = 8
) (
    input  logic           clk,
    input  logic           arstn,
    wb_arbiter_if.slave    bus
);
    localparam logic [0:0]     IDLE = 1'b0;
    localparam logic [0:0]     BUSY = 1'b1;
    localparam logic [TMO-1:0] TLIM = '1;

    logic [0:0]     state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [TMO-1:0] tcount_q, tcount_d;
    logic           busy, own_stb, own_we, ack, done, tmo_hit, any_req, both_req;
    logic [AW-1:0]  adr_sel;
    logic [DW-1:0]  dat_sel;

    assign busy     = state_q == BUSY;
    assign own_stb  = owner_q ? bus.m1_stb_i : bus.m0_stb_i;
    assign own_we   = owner_q ? bus.m1_we_i  : bus.m0_we_i;
    assign adr_sel  = owner_q ? bus.m1_adr_i : bus.m0_adr_i;
    assign dat_sel  = owner_q ? bus.m1_dat_i : bus.m0_dat_i;
    assign any_req  = bus.m0_stb_i | bus.m1_stb_i;
    assign both_req = bus.m0_stb_i & bus.m1_stb_i;
    // A slave ack only counts while a grant is held; an ack at terminal count wins over the timeout.
    assign ack      = busy & bus.s_ack_i;
    assign done     = ack & own_stb;
    assign tmo_hit  = busy & own_stb & ~bus.s_ack_i & (tcount_q == TLIM);

    assign bus.s_stb_o  = busy & own_stb;
    assign bus.s_we_o   = busy & own_we;
    assign bus.s_adr_o  = adr_sel;
    assign bus.s_dat_o  = dat_sel;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.m0_ack_o = ack & ~owner_q;
    assign bus.m1_ack_o = ack & owner_q;
    assign bus.m0_err_o = tmo_hit & ~owner_q;
    assign bus.m1_err_o = tmo_hit & owner_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy;

    // Grant from IDLE (round-robin on a tie); release on ack, abort or timeout and remember who was served.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tcount_d = tcount_q;
        if (!busy) begin
            if (any_req) begin
                state_d  = BUSY;
                owner_d  = both_req ? ~last_q : bus.m1_stb_i;
                tcount_d = '0;
            end
        end else if (done | ~own_stb | tmo_hit) begin
            state_d  = IDLE;
            last_d   = owner_q;
            tcount_d = '0;
        end else begin
            tcount_d = tcount_q + 1'b1;
        end
    end

    // State registers; last starts at 1 so the first tie after reset goes to master 0.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            tcount_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            tcount_q <= tcount_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run checked against a cycle-level behavioural model.
module tb_wb_arbiter;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int LIM = (1 << TMO) - 1;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    wb_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (.clk(clk), .arstn(arstn), .bus(bus));

    // {busy, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}
    function automatic logic [6:0] stat();
        return {bus.busy, bus.s_stb_o, bus.s_we_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o};
    endfunction

    task automatic idle_inputs();
        bus.m0_adr_i = '0; bus.m1_adr_i = '0; bus.m0_dat_i = '0; bus.m1_dat_i = '0;
        bus.m0_we_i = 1'b0; bus.m1_we_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        arstn = 1'b0;
        bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m0_we_i = 1'b1; bus.m1_we_i = 1'b1;
        #3;
        n_chk++; if (stat() !== 7'b0) $display("FAIL reset_outputs got %b want 0000000", stat()); else n_pass++;
        n_chk++; if (bus.owner !== 1'b0) $display("FAIL reset_owner got %b want 0", bus.owner); else n_pass++;
        @(negedge clk);
        arstn = 1'b1;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.busy, bus.owner} !== 2'b10) $display("FAIL reset_first_tie got busy/owner %b want 10", {bus.busy, bus.owner}); else n_pass++;
    endtask

    task automatic test_write();
        apply_reset();
        bus.m0_adr_i = 15'h0010; bus.m0_dat_i = 32'hDEADBEEF; bus.m0_we_i = 1'b1; bus.m0_stb_i = 1'b1;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b0) $display("FAIL wr_req_cycle got %b want 0000000", stat()); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (stat() !== 7'b1110000) $display("FAIL wr_grant got %b want 1110000", stat()); else n_pass++;
        n_chk++; if ({bus.s_adr_o, bus.s_dat_o} !== {15'h0010, 32'hDEADBEEF}) $display("FAIL wr_bus got %h/%h want 0010/deadbeef", bus.s_adr_o, bus.s_dat_o); else n_pass++;
        tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b1111000) $display("FAIL wr_ack got %b want 1111000", stat()); else n_pass++;
        tick();
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b0) $display("FAIL wr_after got %b want 0000000", stat()); else n_pass++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        bus.m0_stb_i = 1'b1; bus.m1_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.s_ack_i = 1'b1;
            @(negedge clk);
            n_chk++; if (stat() !== {3'b110, i[0] == 1'b0, i[0], 2'b00}) $display("FAIL rr_ack[%0d] got %b want %b", i, stat(), {3'b110, i[0] == 1'b0, i[0], 2'b00}); else n_pass++;
            n_chk++; if (bus.owner !== i[0]) $display("FAIL rr_owner[%0d] got %b want %b", i, bus.owner, i[0]); else n_pass++;
            tick();
            bus.s_ack_i = 1'b0;
            @(negedge clk);
            n_chk++; if (stat() !== 7'b0) $display("FAIL rr_idle_gap[%0d] got %b want 0000000", i, stat()); else n_pass++;
        end
        bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;
    endtask

    task automatic test_read();
        apply_reset();
        bus.m1_adr_i = 15'h0020; bus.m1_we_i = 1'b0; bus.m1_stb_i = 1'b1;
        tick();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h12345678;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b1100100) $display("FAIL rd_ack got %b want 1100100", stat()); else n_pass++;
        n_chk++; if (bus.m1_dat_o !== 32'h12345678) $display("FAIL rd_data got %h want 12345678", bus.m1_dat_o); else n_pass++;
        n_chk++; if (bus.owner !== 1'b1) $display("FAIL rd_owner got %b want 1", bus.owner); else n_pass++;
        tick();
        bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0;
    endtask

    task automatic test_timeout();
        int errs = 0;
        apply_reset();
        bus.m0_stb_i = 1'b1;
        tick();
        for (int k = 0; k <= LIM; k++) begin
            @(negedge clk);
            n_chk++; if ({bus.busy, bus.m0_err_o} !== {1'b1, k == LIM}) $display("FAIL tmo_cycle[%0d] got busy/err %b want %b", k, {bus.busy, bus.m0_err_o}, {1'b1, k == LIM}); else n_pass++;
            errs += int'(bus.m0_err_o);
            tick();
        end
        bus.m0_stb_i = 1'b0;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b0) $display("FAIL tmo_release got %b want 0000000", stat()); else n_pass++;
        n_chk++; if (errs !== 1) $display("FAIL tmo_pulses got %0d want 1", errs); else n_pass++;
        tick();
        bus.m0_stb_i = 1'b1;
        tick();
        for (int k = 0; k < LIM; k++) tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b1101000) $display("FAIL tmo_ack_wins got %b want 1101000", stat()); else n_pass++;
        tick();
        bus.s_ack_i = 1'b0; bus.m0_stb_i = 1'b0;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b0) $display("FAIL tmo_ack_after got %b want 0000000", stat()); else n_pass++;
    endtask

    task automatic test_abort();
        apply_reset();
        bus.m1_stb_i = 1'b1;
        tick();
        bus.m0_stb_i = 1'b1;
        @(negedge clk);
        n_chk++; if ({bus.busy, bus.owner} !== 2'b11) $display("FAIL abort_grant got busy/owner %b want 11", {bus.busy, bus.owner}); else n_pass++;
        tick();
        tick();
        bus.m1_stb_i = 1'b0;
        @(negedge clk);
        n_chk++; if (stat() !== 7'b1000000) $display("FAIL abort_cycle got %b want 1000000", stat()); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (stat() !== 7'b0) $display("FAIL abort_idle got %b want 0000000", stat()); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.busy, bus.owner, bus.s_stb_o} !== 3'b101) $display("FAIL abort_next_grant got busy/owner/stb %b want 101", {bus.busy, bus.owner, bus.s_stb_o}); else n_pass++;
        bus.m0_stb_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.m0_we_i = 1'b1; bus.m0_stb_i = 1'b1;
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        n_chk++; if (stat() !== 7'b1111000) $display("FAIL rstmid_pre got %b want 1111000", stat()); else n_pass++;
        arstn = 1'b0;
        #1;
        n_chk++; if (stat() !== 7'b0) $display("FAIL rstmid_async got %b want 0000000", stat()); else n_pass++;
        bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b1;
        @(negedge clk);
        arstn = 1'b1;
        tick();
        @(negedge clk);
        n_chk++; if ({bus.busy, bus.owner} !== 2'b10) $display("FAIL rstmid_tie got busy/owner %b want 10", {bus.busy, bus.owner}); else n_pass++;
        idle_inputs();
    endtask

    // Masters issue random transfers and hold stb until ack/err (occasionally aborting);
    // the slave acks at random and sometimes goes silent for a whole transfer to force timeouts.
    task automatic test_random();
        bit            pend[2];
        logic [AW-1:0] adr[2];
        logic [DW-1:0] dat[2];
        logic          we[2];
        bit            mb, mute, own, sack, s0, s1;
        int            mo, ml, mc;
        logic [6:0]    exp_st;
        logic [DW-1:0] sdat;
        apply_reset();
        pend = '{1'b0, 1'b0}; we = '{1'b0, 1'b0}; adr = '{'0, '0}; dat = '{'0, '0};
        mb = 1'b0; mo = 0; ml = 1; mc = 0; mute = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(3) == 0) begin
                    pend[n] = 1'b1; adr[n] = AW'($urandom); dat[n] = $urandom; we[n] = 1'($urandom_range(1));
                end else if (pend[n] && mb && mo == n && $urandom_range(39) == 0) begin
                    pend[n] = 1'b0;
                end
            end
            bus.m0_stb_i = pend[0]; bus.m0_adr_i = adr[0]; bus.m0_dat_i = dat[0]; bus.m0_we_i = we[0];
            bus.m1_stb_i = pend[1]; bus.m1_adr_i = adr[1]; bus.m1_dat_i = dat[1]; bus.m1_we_i = we[1];
            own = pend[mo];
            if (!mb) mute = ($urandom_range(5) == 0);
            sack = (mb && own) ? (!mute && $urandom_range(2) == 0) : (!mb && $urandom_range(3) == 0);
            sdat = $urandom;
            bus.s_ack_i = sack; bus.s_dat_i = sdat;
            exp_st = {mb, mb && own, mb && we[mo], mb && sack && mo == 0, mb && sack && mo == 1,
                      mb && own && !sack && mc == LIM && mo == 0, mb && own && !sack && mc == LIM && mo == 1};
            @(negedge clk);
            n_chk++; if (stat() !== exp_st) $display("FAIL rnd_status[%0d] got %b want %b", c, stat(), exp_st); else n_pass++;
            n_chk++; if ({bus.m0_dat_o, bus.m1_dat_o} !== {sdat, sdat}) $display("FAIL rnd_rdata[%0d] got %h/%h want %h", c, bus.m0_dat_o, bus.m1_dat_o, sdat); else n_pass++;
            if (mb) begin
                n_chk++; if ({bus.owner, bus.s_adr_o, bus.s_dat_o} !== {mo[0], adr[mo], dat[mo]}) $display("FAIL rnd_route[%0d] got %b/%h/%h want %b/%h/%h", c, bus.owner, bus.s_adr_o, bus.s_dat_o, mo[0], adr[mo], dat[mo]); else n_pass++;
            end
            s0 = pend[0]; s1 = pend[1];
            if (exp_st[3] || exp_st[1]) pend[0] = 1'b0;
            if (exp_st[2] || exp_st[0]) pend[1] = 1'b0;
            if (!mb) begin
                if (s0 || s1) begin
                    mb = 1'b1; mo = (s0 && s1) ? 1 - ml : (s1 ? 1 : 0); mc = 0;
                end
            end else if ((sack && own) || !own || mc == LIM) begin
                mb = 1'b0; ml = mo; mc = 0;
            end else begin
                mc++;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
